// File: rtl/clause_setup_loader_pkg.sv
// Shared definitions for the clause-setup loader.
// Holds the FSM state encoding, default parameter values, derived
// coefficient-bus width helpers and the default clause count.
// Optional build macro: CLAUSE_LOADER_ZERO_FILL_EN adds the FILL state.
package clause_setup_loader_pkg;

  localparam int unsigned DEF_WIC = 4;  // bits per integer coefficient
  localparam int unsigned DEF_WBC = 2;  // bits per boolean coefficient
  localparam int unsigned DEF_I   = 1;  // log2 integer variables
  localparam int unsigned DEF_B   = 1;  // log2 boolean variables
  localparam int unsigned DEF_C   = 2;  // log2 clauses

  // Integer bus carries one coefficient per integer variable plus the bias.
  function automatic int unsigned int_coef_width(input int unsigned wic, input int unsigned iw);
    return ((32'd1 << iw) + 32'd1) * wic;
  endfunction

  function automatic int unsigned bool_coef_width(input int unsigned wbc, input int unsigned bw);
    return wbc * (32'd1 << bw);
  endfunction

  localparam int unsigned INT_COEF_W        = int_coef_width(DEF_WIC, DEF_I);
  localparam int unsigned BOOL_COEF_W       = bool_coef_width(DEF_WBC, DEF_B);
  localparam int unsigned NUMBER_OF_CLAUSES = 32'd1 << DEF_C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2
`ifdef CLAUSE_LOADER_ZERO_FILL_EN
    ,
    ST_FILL   = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/clause_setup_loader_decoder.sv
// clause_index_decoder: binary index to one-hot decoder, gated by enable.
// Ports:
//   en_i     - when low the output is all zero
//   idx_i    - binary slot index
//   onehot_c - combinational one-hot of idx_i (2^IDX_W bits)
module clause_index_decoder #(
  parameter int unsigned IDX_W = 2
) (
  input  logic               en_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [2**IDX_W-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en_i) onehot_c[idx_i] = 1'b1;
  end

endmodule

// File: rtl/clause_setup_loader.sv
// clause_setup_loader: turns a valid/ready stream of clause records into
// one-cycle clause writes (index, one-hot write enable, coefficients),
// builds the loaded-clause mask and flags completion / slot overflow.
// Ports:
//   in_clk, in_reset                   - clock, async active-high reset
//   in_start                           - begin a load (ignored while busy)
//   in_clause_valid/out_clause_ready   - record handshake
//   in_clause_last                     - final record of the formula
//   in_clause_coefficients_*           - record payload
//   out_clause_index, out_clauses_write_enable, out_clause_coefficients_*
//                                      - clause write port (registered)
//   out_clauses_enable                 - mask of loaded clauses
//   out_busy, out_done, out_error      - status
// Optional build macro: CLAUSE_LOADER_ZERO_FILL_EN zero-fills unused slots
// after a short formula.
module clause_setup_loader
  import clause_setup_loader_pkg::*;
#(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = DEF_WIC,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = DEF_WBC,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = DEF_I,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = DEF_B,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = DEF_C,
  localparam int unsigned IW = int_coef_width(MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
                                              MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX),
  localparam int unsigned BW = bool_coef_width(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT,
                                               MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX),
  localparam int unsigned CW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int unsigned NC = 2 ** CW
) (
  input  logic          in_clk,
  input  logic          in_reset,
  input  logic          in_start,
  input  logic          in_clause_valid,
  output logic          out_clause_ready,
  input  logic          in_clause_last,
  input  logic [IW-1:0] in_clause_coefficients_integer,
  input  logic [BW-1:0] in_clause_coefficients_boolean,
  output logic [CW-1:0] out_clause_index,
  output logic [NC-1:0] out_clauses_write_enable,
  output logic [IW-1:0] out_clause_coefficients_integer,
  output logic [BW-1:0] out_clause_coefficients_boolean,
  output logic [NC-1:0] out_clauses_enable,
  output logic          out_busy,
  output logic          out_done,
  output logic          out_error
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic          last_q, last_d;
  logic [IW-1:0] ci_q, ci_d;
  logic [BW-1:0] cb_q, cb_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [NC-1:0] we_q, we_d;
  logic [NC-1:0] mask_q, mask_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          ready_q, ready_d;
  logic          dec_en;
  logic [CW-1:0] dec_idx;

  assign cnt_nxt = cnt_q + CW'(1);

  // Write-enable for the cycle after the current one.
  clause_index_decoder #(.IDX_W(CW)) u_dec (
    .en_i     (dec_en),
    .idx_i    (dec_idx),
    .onehot_c (we_d)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ci_d    = ci_q;
    cb_d    = cb_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    done_d  = done_q;
    error_d = error_q;
    dec_en  = 1'b0;
    dec_idx = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          state_d = ST_ACCEPT;
          cnt_d   = '0;
          mask_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (in_clause_valid && ready_q) begin
          state_d = ST_WRITE;
          ci_d    = in_clause_coefficients_integer;
          cb_d    = in_clause_coefficients_boolean;
          last_d  = in_clause_last;
          idx_d   = cnt_q;
          dec_en  = 1'b1;
        end
      end
      ST_WRITE: begin
        mask_d[cnt_q] = 1'b1;
        if (last_q) begin
`ifdef CLAUSE_LOADER_ZERO_FILL_EN
          if (!(&cnt_q)) begin
            state_d = ST_FILL;
            cnt_d   = cnt_nxt;
            idx_d   = cnt_nxt;
            dec_idx = cnt_nxt;
            dec_en  = 1'b1;
            ci_d    = '0;
            cb_d    = '0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else if (&cnt_q) begin
          // More records than slots: stop without wrapping the counter.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          state_d = ST_ACCEPT;
          cnt_d   = cnt_nxt;
        end
      end
`ifdef CLAUSE_LOADER_ZERO_FILL_EN
      ST_FILL: begin
        // Filled slots are written but left out of the enable mask.
        if (&cnt_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_nxt;
          idx_d   = cnt_nxt;
          dec_idx = cnt_nxt;
          dec_en  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_ACCEPT);
  end

  // State and output registers.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ci_q    <= '0;
      cb_q    <= '0;
      idx_q   <= '0;
      we_q    <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ci_q    <= ci_d;
      cb_q    <= cb_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      ready_q <= ready_d;
    end
  end

  assign out_clause_ready                = ready_q;
  assign out_clause_index                = idx_q;
  assign out_clauses_write_enable        = we_q;
  assign out_clause_coefficients_integer = ci_q;
  assign out_clause_coefficients_boolean = cb_q;
  assign out_clauses_enable              = mask_q;
  assign out_busy                        = busy_q;
  assign out_done                        = done_q;
  assign out_error                       = error_q;

endmodule

// File: tb/tb_clause_setup_loader.sv
// Scoreboard bench for clause_setup_loader at default parameters
// (12-bit integer bus, 4-bit boolean bus, 4 clause slots).
module tb_clause_setup_loader;

  logic        in_clk = 1'b0;
  logic        in_reset = 1'b1;
  logic        in_start = 1'b0;
  logic        in_clause_valid = 1'b0;
  logic        out_clause_ready;
  logic        in_clause_last = 1'b0;
  logic [11:0] in_clause_coefficients_integer = '0;
  logic [3:0]  in_clause_coefficients_boolean = '0;
  logic [1:0]  out_clause_index;
  logic [3:0]  out_clauses_write_enable;
  logic [11:0] out_clause_coefficients_integer;
  logic [3:0]  out_clause_coefficients_boolean;
  logic [3:0]  out_clauses_enable;
  logic        out_busy;
  logic        out_done;
  logic        out_error;

  clause_setup_loader dut (
    .in_clk                          (in_clk),
    .in_reset                        (in_reset),
    .in_start                        (in_start),
    .in_clause_valid                 (in_clause_valid),
    .out_clause_ready                (out_clause_ready),
    .in_clause_last                  (in_clause_last),
    .in_clause_coefficients_integer  (in_clause_coefficients_integer),
    .in_clause_coefficients_boolean  (in_clause_coefficients_boolean),
    .out_clause_index                (out_clause_index),
    .out_clauses_write_enable        (out_clauses_write_enable),
    .out_clause_coefficients_integer (out_clause_coefficients_integer),
    .out_clause_coefficients_boolean (out_clause_coefficients_boolean),
    .out_clauses_enable              (out_clauses_enable),
    .out_busy                        (out_busy),
    .out_done                        (out_done),
    .out_error                       (out_error)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [1:0]  idx;
    logic [3:0]  we;
    logic [11:0] ci;
    logic [3:0]  cb;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge in_clk) begin
    if (out_clauses_write_enable !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {28'd0, out_clauses_write_enable}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_we",    {28'd0, out_clauses_write_enable},        {28'd0, e.we});
        check("wr_index", {30'd0, out_clause_index},                {30'd0, e.idx});
        check("wr_int",   {20'd0, out_clause_coefficients_integer}, {20'd0, e.ci});
        check("wr_bool",  {28'd0, out_clause_coefficients_boolean}, {28'd0, e.cb});
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, out_clause_ready}, 32'd0);
    check({tag, "_we"},    {28'd0, out_clauses_write_enable}, 32'd0);
    check({tag, "_index"}, {30'd0, out_clause_index}, 32'd0);
    check({tag, "_int"},   {20'd0, out_clause_coefficients_integer}, 32'd0);
    check({tag, "_bool"},  {28'd0, out_clause_coefficients_boolean}, 32'd0);
    check({tag, "_mask"},  {28'd0, out_clauses_enable}, 32'd0);
    check({tag, "_busy"},  {31'd0, out_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, out_done}, 32'd0);
    check({tag, "_error"}, {31'd0, out_error}, 32'd0);
  endtask

  task automatic start_load;
    in_start = 1'b1;
    tick;
    in_start = 1'b0;
    check("start_busy",  {31'd0, out_busy}, 32'd1);
    check("start_ready", {31'd0, out_clause_ready}, 32'd1);
    check("start_mask",  {28'd0, out_clauses_enable}, 32'd0);
    check("start_done",  {31'd0, out_done}, 32'd0);
    check("start_error", {31'd0, out_error}, 32'd0);
  endtask

  // Present one record, wait (bounded) for the handshake, queue the write.
  task automatic send(input logic [11:0] ci, input logic [3:0] cb, input logic last, input int slot);
    int waited;
    wr_t e;
    waited = 0;
    in_clause_valid = 1'b1;
    in_clause_coefficients_integer = ci;
    in_clause_coefficients_boolean = cb;
    in_clause_last = last;
    while (!out_clause_ready && waited < 20) begin
      tick;
      waited++;
    end
    if (!out_clause_ready) begin
      check("send_ready_timeout", {31'd0, out_clause_ready}, 32'd1);
      in_clause_valid = 1'b0;
      return;
    end
    e.idx = 2'(slot);
    e.we  = 4'(1 << slot);
    e.ci  = ci;
    e.cb  = cb;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    tick;
    in_clause_valid = 1'b0;
    in_clause_last = 1'b0;
  endtask

  // Called during the WRITE of the last record; returns once done is up.
  task automatic finish_wait(input int n_loaded);
    int n_ticks;
    n_ticks = 1;
`ifdef CLAUSE_LOADER_ZERO_FILL_EN
    for (int s = n_loaded; s < 4; s++) begin
      wr_t e;
      e.idx = 2'(s);
      e.we  = 4'(1 << s);
      e.ci  = '0;
      e.cb  = '0;
      e.cyc = cyc + (s - n_loaded + 1);
      exp_q.push_back(e);
    end
    n_ticks = 5 - n_loaded;
`endif
    for (int i = 0; i < n_ticks; i++) begin
      tick;
      in_start = 1'b0;
    end
    check("fin_done", {31'd0, out_done}, 32'd1);
    check("fin_busy", {31'd0, out_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    tick;
    check_all_zero("reset");
    in_reset = 1'b0;
    tick;

    // Reset in the middle of a WRITE cycle.
    start_load;
    send(12'h0F0, 4'h5, 1'b0, 0);
    @(negedge in_clk);
    #1;
    in_reset = 1'b1;
    #1;
    check_all_zero("midreset");
    tick;
    in_reset = 1'b0;
    tick;

    // Full four-record formula.
    start_load;
    send(12'h1A3, 4'h9, 1'b0, 0);
    send(12'h2B4, 4'hA, 1'b0, 1);
    send(12'h3C5, 4'hB, 1'b0, 2);
    send(12'h4D6, 4'hC, 1'b1, 3);
    finish_wait(4);
    check("full_mask",  {28'd0, out_clauses_enable}, 32'hF);
    check("full_error", {31'd0, out_error}, 32'd0);
    check("full_hold",  {20'd0, out_clause_coefficients_integer}, 32'h4D6);
    tick;
    check("full_done_held", {31'd0, out_done}, 32'd1);

    // Two-record formula.
    start_load;
    send(12'h5E7, 4'h3, 1'b0, 0);
    send(12'h6F8, 4'h6, 1'b1, 1);
    finish_wait(2);
    check("two_mask",  {28'd0, out_clauses_enable}, 32'h3);
    check("two_error", {31'd0, out_error}, 32'd0);
`ifdef CLAUSE_LOADER_ZERO_FILL_EN
    check("two_hold", {20'd0, out_clause_coefficients_integer}, 32'h000);
`else
    check("two_hold", {20'd0, out_clause_coefficients_integer}, 32'h6F8);
`endif

    // Valid held low in ACCEPT.
    start_load;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("idle_ready", {31'd0, out_clause_ready}, 32'd1);
      check("idle_busy",  {31'd0, out_busy}, 32'd1);
    end
    send(12'h777, 4'h7, 1'b1, 0);
    finish_wait(1);
    check("idle_mask", {28'd0, out_clauses_enable}, 32'h1);

    // Overflow: five records, none marked last.
    start_load;
    send(12'h111, 4'h1, 1'b0, 0);
    send(12'h222, 4'h2, 1'b0, 1);
    send(12'h333, 4'h3, 1'b0, 2);
    send(12'h444, 4'h4, 1'b0, 3);
    tick;
    check("ovf_error", {31'd0, out_error}, 32'd1);
    check("ovf_done",  {31'd0, out_done}, 32'd1);
    check("ovf_ready", {31'd0, out_clause_ready}, 32'd0);
    check("ovf_busy",  {31'd0, out_busy}, 32'd0);
    check("ovf_mask",  {28'd0, out_clauses_enable}, 32'hF);
    in_clause_valid = 1'b1;
    in_clause_coefficients_integer = 12'h555;
    in_clause_coefficients_boolean = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("ovf_fifth_ready", {31'd0, out_clause_ready}, 32'd0);
    end
    in_clause_valid = 1'b0;
    check("ovf_error_held", {31'd0, out_error}, 32'd1);

    // Start pulsed during WRITE, and in the cycle the load finishes.
    start_load;
    send(12'hABC, 4'hD, 1'b0, 0);
    in_start = 1'b1;
    tick;
    in_start = 1'b0;
    send(12'hDEF, 4'hE, 1'b1, 1);
    in_start = 1'b1;
    finish_wait(2);
    check("st_mask",  {28'd0, out_clauses_enable}, 32'h3);
    check("st_error", {31'd0, out_error}, 32'd0);
    tick;
    tick;
    check("st_stays_idle", {31'd0, out_busy}, 32'd0);
    check("st_done_held",  {31'd0, out_done}, 32'd1);

    tick;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
